// File: rtl/ulx3s_pll_phase_ctrl.sv
// ECP5 EHXPLLL supervisor: lock filter, downstream reset hold and dynamic phase-step sequencer.
// Define PLL_PHASE_POS_EN to implement the per-channel net phase position counters.
module ulx3s_pll_phase_ctrl #(
   parameter int CHANNELS    = 4,
   parameter int STEP_PULSE  = 4,
   parameter int SETTLE      = 8,
   parameter int LOCK_FILTER = 1024
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pll_locked,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_channel,
   input  logic                  req_dir,
   input  logic [7:0]            req_steps,
   output logic                  req_err,
   output logic                  busy,
   output logic [1:0]            phasesel,
   output logic                  phasedir,
   output logic                  phasestep,
   output logic                  phaseloadreg,
   output logic                  lock_ok,
   output logic                  rst_hold,
   output logic [8*CHANNELS-1:0] phase_pos
);

   // state    | meaning
   // LOCKWAIT | filtering synchronised lock, downstream held in reset
   // IDLE     | locked, accepting requests
   // SETUP    | phasesel/phasedir set up ahead of the first step
   // PULSE    | phasestep low for STEP_PULSE cycles
   // SETTLE   | phasestep high for SETTLE cycles, step counted at the end
   typedef enum logic [2:0] {
      S_LOCKWAIT, S_IDLE, S_SETUP, S_PULSE, S_SETTLE
   } state_t;

   localparam int LCW  = ($clog2(LOCK_FILTER + 1) > 24) ? $clog2(LOCK_FILTER + 1) : 24;
   localparam int TMAX = (STEP_PULSE > SETTLE) ? STEP_PULSE : SETTLE;
   localparam int TW   = $clog2(TMAX + 1);

   state_t          state_q, state_d;
   logic            sync1_q, sync2_q;
   logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [7:0]      remain_q, remain_d;
   logic [1:0]      phasesel_q, phasesel_d;
   logic            phasedir_q, phasedir_d;
   logic            phasestep_q, phasestep_d;
   logic            req_err_q, req_err_d;
   logic            req_ready_q, req_ready_d;
   logic            busy_q, busy_d;
   logic            lock_ok_q, lock_ok_d;
   logic            step_done, lock_lost;

   assign step_done = (state_q == S_SETTLE) && (tmr_q == '0);
   assign lock_lost = (state_q != S_LOCKWAIT) && !sync2_q;

   always_comb begin
      state_d     = state_q;
      lock_cnt_d  = lock_cnt_q;
      tmr_d       = tmr_q;
      remain_d    = remain_q;
      phasesel_d  = phasesel_q;
      phasedir_d  = phasedir_q;
      phasestep_d = phasestep_q;
      req_err_d   = 1'b0;
      case (state_q)
         S_LOCKWAIT: begin
            if (!sync2_q) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LCW'(LOCK_FILTER - 1)) begin
               lock_cnt_d = '0;
               state_d    = S_IDLE;
            end else begin
               lock_cnt_d = lock_cnt_q + 1'b1;
            end
         end
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               if (int'(req_channel) >= CHANNELS) begin
                  req_err_d = 1'b1;
               end else if (req_steps != 8'd0) begin
                  state_d    = S_SETUP;
                  phasesel_d = req_channel;
                  phasedir_d = req_dir;
                  remain_d   = req_steps;
               end
            end
         end
         S_SETUP: begin
            state_d     = S_PULSE;
            phasestep_d = 1'b0;
            tmr_d       = TW'(STEP_PULSE - 1);
         end
         S_PULSE: begin
            if (tmr_q == '0) begin
               state_d     = S_SETTLE;
               phasestep_d = 1'b1;
               tmr_d       = TW'(SETTLE - 1);
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         S_SETTLE: begin
            if (step_done) begin
               remain_d = remain_q - 8'd1;
               if (remain_q == 8'd1) begin
                  state_d = S_IDLE;
               end else begin
                  state_d     = S_PULSE;
                  phasestep_d = 1'b0;
                  tmr_d       = TW'(STEP_PULSE - 1);
               end
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = S_LOCKWAIT;
      endcase
      // Lock loss overrides everything: abandon the sequence, step in flight is not counted.
      if (lock_lost) begin
         state_d     = S_LOCKWAIT;
         lock_cnt_d  = '0;
         remain_d    = 8'd0;
         phasestep_d = 1'b1;
         req_err_d   = 1'b0;
      end
      req_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_SETTLE);
      lock_ok_d   = (state_d != S_LOCKWAIT);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= S_LOCKWAIT;
         lock_cnt_q  <= '0;
         tmr_q       <= '0;
         remain_q    <= 8'd0;
         phasesel_q  <= 2'd0;
         phasedir_q  <= 1'b0;
         phasestep_q <= 1'b1;
         req_err_q   <= 1'b0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         lock_ok_q   <= 1'b0;
      end else begin
         sync1_q     <= pll_locked;
         sync2_q     <= sync1_q;
         state_q     <= state_d;
         lock_cnt_q  <= lock_cnt_d;
         tmr_q       <= tmr_d;
         remain_q    <= remain_d;
         phasesel_q  <= phasesel_d;
         phasedir_q  <= phasedir_d;
         phasestep_q <= phasestep_d;
         req_err_q   <= req_err_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         lock_ok_q   <= lock_ok_d;
      end
   end

`ifdef PLL_PHASE_POS_EN
   logic [8*CHANNELS-1:0] pos_q, pos_d;

   // phasesel_q holds the latched channel for the whole sequence.
   always_comb begin
      pos_d = pos_q;
      if (lock_lost) begin
         pos_d = '0;
      end else if (step_done) begin
         for (int n = 0; n < CHANNELS; n++) begin
            if (phasesel_q == 2'(n)) begin
               pos_d[8*n +: 8] = pos_q[8*n +: 8] + (phasedir_q ? 8'h01 : 8'hFF);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) pos_q <= '0;
      else       pos_q <= pos_d;
   end

   assign phase_pos = pos_q;
`else
   assign phase_pos = '0;
`endif

   assign req_ready    = req_ready_q;
   assign req_err      = req_err_q;
   assign busy         = busy_q;
   assign phasesel     = phasesel_q;
   assign phasedir     = phasedir_q;
   assign phasestep    = phasestep_q;
   assign phaseloadreg = 1'b1;
   assign lock_ok      = lock_ok_q;
   assign rst_hold     = !lock_ok_q;

endmodule
